pipe_stage: RTL and testbench
=============================

PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath payload width.
REQ-002 SHALL have parameter CTRL_W, default 5, control-bundle width (ctrl_EXE/MEM/WB style).
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have port reloj, input, 1, sole clock; all state on its rising edge.
REQ-005 SHALL have port resetM, input, 1; one clock, reset asynchronous and active-low.
REQ-006 SHALL have port flush, input, 1, synchronous bubble/kill request.
REQ-007 SHALL have port in_valid, input, 1, upstream stage holds a valid instruction.
REQ-008 SHALL have port in_ready, output, 1, stage accepts in this cycle.
REQ-009 SHALL have port in_data, input, DATA_W, upstream payload.
REQ-010 SHALL have port in_ctrl, input, CTRL_W, upstream control bundle.
REQ-011 SHALL have port out_valid, output, 1, registered valid to downstream.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts.
REQ-013 SHALL have port out_data, output, DATA_W, registered payload.
REQ-014 SHALL have port out_ctrl, output, CTRL_W, registered control bundle.
REQ-015 SHALL have port stall_cnt, output, CNT_W, count of back-pressured cycles.

Function
REQ-016 SHALL transfer on input side when in_valid && in_ready, and on output side when out_valid && out_ready.
REQ-017 SHALL present accepted data on out_* the cycle after acceptance (latency 1) when the output register is empty or drains that cycle.
REQ-018 SHALL hold out_data/out_ctrl/out_valid stable while out_valid && !out_ready.
REQ-019 SHALL keep entries in acceptance order; no drop, no duplication except by flush.
REQ-020 SHALL, on flush=1, clear out_valid and every buffered entry next cycle and force out_ctrl to all-zero (NOP bubble); out_data unspecified.
REQ-021 SHALL drive in_ready=0 during flush; flush wins over a simultaneous input transfer (input not taken).
REQ-022 SHALL, with flush=0, load the output register when it is empty or out_ready=1.
REQ-023 SHALL increment stall_cnt each cycle out_valid && !out_ready && !flush, saturating at 2^CNT_W-1 without wrap.
REQ-024 SHALL not clear stall_cnt on flush; only reset clears it.

Reset
REQ-025 SHALL, on resetM=0, asynchronously set out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0 and empty all buffers.
REQ-026 SHALL, during reset, drive in_ready=0; in_ready rises no earlier than the first rising edge after release.
REQ-027 SHALL discard any in-flight entry when reset asserts mid-transfer; no partial state survives.

Configuration
REQ-028 SHALL, when PIPE_STAGE_SKID_EN is defined, include a one-entry skid register: in_ready registered as !skid_valid, entry captured into skid when output stalled, skid moved to output before any new input; full throughput with out_ready toggling.
REQ-029 SHALL, when PIPE_STAGE_SKID_EN is undefined, contain no skid register; in_ready = !flush && (!out_valid || out_ready) combinationally.

Structure
REQ-030 SHALL take default widths and the NOP control encoding (all zero) from shared package mips_pkg.
REQ-031 SHALL implement the skid entry as sub-module pipe_skid (valid + DATA_W + CTRL_W register, load/unload controls), instantiated only under PIPE_STAGE_SKID_EN.
REQ-032 SHALL be instantiable in place of each fixed IF_ID/ID_EX/EX_MEM/MEM_WB latch with widths set per stage.

Verification
REQ-033 SHALL cover: reset, then in_valid=1, in_data=0x12345678, in_ctrl=0x15, out_ready=1 -> out_valid=1, out_data=0x12345678, out_ctrl=0x15 one cycle later.
REQ-034 SHALL cover: out_ready=0 for 4 cycles with out_valid=1 -> out_* stable, stall_cnt=4; with skid, second word held and emitted next after release.
REQ-035 SHALL cover: flush=1 with in_valid=1 and out_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=0 during flush, input word never emitted.
REQ-036 SHALL cover: CNT_W=3, out_ready=0 for 10 cycles -> stall_cnt saturates at 7.
REQ-037 SHALL cover: resetM=0 asserted mid-stall between edges -> all outputs zero immediately, in_ready=0.
REQ-038 SHALL cover: 100 random in_valid/out_ready patterns, both macro settings -> output sequence equals input sequence, skid build sustains 1 word/cycle when out_ready=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: default latch widths and the NOP control encoding.
// Imported by pipe_stage and pipe_skid.
package mips_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CTRL_W_DEF = 5;
  localparam int unsigned CNT_W_DEF  = 16;

  // A NOP bubble is an all-zero control bundle at any width; replicate this bit.
  localparam logic CTRL_NOP_BIT = 1'b0;

endpackage

// File: rtl/pipe_skid.sv
// One-entry skid register for pipe_stage: holds a word accepted while the output
// register is stalled. Instantiated only when PIPE_STAGE_SKID_EN is defined.
module pipe_skid
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF
) (
  input  logic              reloj,
  input  logic              resetM,
  input  logic              clear,
  input  logic              load,
  input  logic              unload,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              skid_valid,
  output logic [DATA_W-1:0] skid_data,
  output logic [CTRL_W-1:0] skid_ctrl
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= {CTRL_W{CTRL_NOP_BIT}};
    end else if (clear) begin
      valid_q <= 1'b0;
      ctrl_q  <= {CTRL_W{CTRL_NOP_BIT}};
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
      ctrl_q  <= in_ctrl;
    end else if (unload) begin
      valid_q <= 1'b0;
    end
  end

  assign skid_valid = valid_q;
  assign skid_data  = data_q;
  assign skid_ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage.sv
// Elastic pipeline latch (IF_ID/ID_EX/EX_MEM/MEM_WB) with flush-to-NOP and a saturating
// back-pressure counter. Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer.
module pipe_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              reloj,
  input  logic              resetM,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              rdy_q;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              in_fire;
  logic              out_load;

  // Keeps in_ready low until the first rising edge after reset release.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic              skid_load;
  logic              skid_unload;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  assign in_ready = rdy_q && !skid_valid && !flush;

  pipe_skid #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) u_skid (
    .reloj     (reloj),
    .resetM    (resetM),
    .clear     (flush),
    .load      (skid_load),
    .unload    (skid_unload),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .skid_valid(skid_valid),
    .skid_data (skid_data),
    .skid_ctrl (skid_ctrl)
  );
`else
  assign in_ready = rdy_q && !flush && (!out_valid_q || out_ready);
`endif

  assign in_fire  = in_valid && in_ready;
  assign out_load = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ctrl_d  = out_ctrl_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_load   = 1'b0;
    skid_unload = 1'b0;
`endif
    if (flush) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = {CTRL_W{CTRL_NOP_BIT}};
    end else if (out_load) begin
`ifdef PIPE_STAGE_SKID_EN
      // The skid entry is older than anything at the input, so it drains first.
      if (skid_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = skid_data;
        out_ctrl_d  = skid_ctrl;
        skid_unload = 1'b1;
      end else if (in_fire) begin
`else
      if (in_fire) begin
`endif
        out_valid_d = 1'b1;
        out_data_d  = in_data;
        out_ctrl_d  = in_ctrl;
      end else begin
        out_valid_d = 1'b0;
      end
    end
`ifdef PIPE_STAGE_SKID_EN
    else if (in_fire) begin
      skid_load = 1'b1;
    end
`endif
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid_q && !out_ready && !flush && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ctrl_q  <= {CTRL_W{CTRL_NOP_BIT}};
      stall_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ctrl_q  <= out_ctrl_d;
      stall_q     <= stall_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ctrl  = out_ctrl_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage against a queue-based reference model.
// Works for both the default build and PIPE_STAGE_SKID_EN.
module tb_pipe_stage;

  localparam int STALL_MAX = 7;

  logic        reloj = 1'b0;
  logic        resetM;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_ctrl;
  logic [2:0]  stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words accepted and not yet delivered, in order.
  logic [31:0] q_data[$];
  logic [4:0]  q_ctrl[$];
  int          stall_model;
  bit          rdy_en;
  int          n_in;
  int          n_out;

  pipe_stage #(
    .DATA_W(32),
    .CTRL_W(5),
    .CNT_W (3)
  ) dut (
    .reloj    (reloj),
    .resetM   (resetM),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .stall_cnt(stall_cnt)
  );

  always #5 reloj = ~reloj;

  function automatic logic model_valid();
    return q_data.size() > 0;
  endfunction

  // Capacity is one word without the skid buffer, two with it.
  function automatic logic model_ready();
`ifdef PIPE_STAGE_SKID_EN
    return rdy_en && !flush && (q_data.size() < 2);
`else
    return rdy_en && !flush && (q_data.size() == 0 || out_ready);
`endif
  endfunction

  function automatic void model_clear();
    q_data.delete();
    q_ctrl.delete();
    stall_model = 0;
    rdy_en      = 1'b0;
  endfunction

  // Advance one rising edge, updating the model from the inputs held before it.
  task automatic advance();
    logic acc, pop, stl;
    logic [31:0] d;
    logic [4:0]  c;
    acc = in_valid && model_ready();
    pop = model_valid() && out_ready;
    stl = model_valid() && !out_ready && !flush;
    d   = in_data;
    c   = in_ctrl;
    @(posedge reloj);
    if (flush) begin
      q_data.delete();
      q_ctrl.delete();
    end else begin
      if (pop) begin
        void'(q_data.pop_front());
        void'(q_ctrl.pop_front());
        n_out++;
      end
      if (acc) begin
        q_data.push_back(d);
        q_ctrl.push_back(c);
        n_in++;
      end
    end
    if (stl && stall_model < STALL_MAX) stall_model++;
    if (resetM) rdy_en = 1'b1;
    #1;
  endtask

  task automatic reset_dut();
    @(negedge reloj);
    resetM    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    model_clear();
    #3;
    resetM = 1'b1;
    advance();
  endtask

  task automatic test_reset();
    resetM    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'hDEADBEEF;
    in_ctrl   = 5'h1F;
    model_clear();
    repeat (2) @(posedge reloj);
    #2;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if (out_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data);
    end
    n_checks++;
    if (out_ctrl !== 5'h0) begin
      n_fail++; $display("FAIL reset_out_ctrl: got %h want 0", out_ctrl);
    end
    n_checks++;
    if (stall_cnt !== 3'd0) begin
      n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    @(negedge reloj);
    resetM = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL release_in_ready: got %b want 0 before first edge", in_ready);
    end
    advance();
    in_valid = 1'b0;
    @(negedge reloj);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_release_in_ready: got %b want 1", in_ready);
    end
    advance();
  endtask

  task automatic test_basic();
    in_valid  = 1'b1;
    in_data   = 32'h12345678;
    in_ctrl   = 5'h15;
    out_ready = 1'b1;
    @(negedge reloj);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_in_ready: got %b want 1", in_ready);
    end
    advance();
    in_valid = 1'b0;
    @(negedge reloj);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_out_valid: got %b want 1", out_valid);
    end
    n_checks++;
    if (out_data !== 32'h12345678) begin
      n_fail++; $display("FAIL basic_out_data: got %h want 12345678", out_data);
    end
    n_checks++;
    if (out_ctrl !== 5'h15) begin
      n_fail++; $display("FAIL basic_out_ctrl: got %h want 15", out_ctrl);
    end
    advance();
  endtask

  task automatic test_stall();
    reset_dut();
    in_valid  = 1'b1;
    in_data   = 32'hAAAA0001;
    in_ctrl   = 5'h0A;
    out_ready = 1'b0;
    @(negedge reloj);
    advance();
    in_data = 32'hBBBB0002;
    in_ctrl = 5'h0B;
    for (int k = 0; k < 4; k++) begin
      @(negedge reloj);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hAAAA0001 || out_ctrl !== 5'h0A) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b d=%h c=%h want v=1 d=aaaa0001 c=0a",
                 k, out_valid, out_data, out_ctrl);
      end
      n_checks++;
      if (stall_cnt !== 3'(k)) begin
        n_fail++; $display("FAIL stall_cnt_step[%0d]: got %0d want %0d", k, stall_cnt, k);
      end
      advance();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge reloj);
    n_checks++;
    if (stall_cnt !== 3'd4) begin
      n_fail++; $display("FAIL stall_cnt_4: got %0d want 4", stall_cnt);
    end
    n_checks++;
    if (out_data !== 32'hAAAA0001) begin
      n_fail++; $display("FAIL stall_release_data: got %h want aaaa0001", out_data);
    end
    advance();
    @(negedge reloj);
`ifdef PIPE_STAGE_SKID_EN
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hBBBB0002 || out_ctrl !== 5'h0B) begin
      n_fail++;
      $display("FAIL skid_second_word: got v=%b d=%h c=%h want v=1 d=bbbb0002 c=0b",
               out_valid, out_data, out_ctrl);
    end
`else
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL noskid_after_release: got v=%b want 0", out_valid);
    end
`endif
    n_checks++;
    if (stall_cnt !== 3'd4) begin
      n_fail++; $display("FAIL stall_cnt_kept: got %0d want 4", stall_cnt);
    end
    advance();
  endtask

  task automatic test_flush();
    reset_dut();
    in_valid  = 1'b1;
    in_data   = 32'hC0C0C0C0;
    in_ctrl   = 5'h1C;
    out_ready = 1'b0;
    @(negedge reloj);
    advance();
    // One stalled cycle; the skid build also takes this word into its buffer.
    in_data = 32'hE0E0E0E0;
    in_ctrl = 5'h0E;
    @(negedge reloj);
    advance();
    flush   = 1'b1;
    in_data = 32'hD0D0D0D0;
    in_ctrl = 5'h0D;
    @(negedge reloj);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre_valid: got %b want 1", out_valid);
    end
    advance();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge reloj);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_out_valid[%0d]: got %b want 0", k, out_valid);
      end
      n_checks++;
      if (out_ctrl !== 5'h0) begin
        n_fail++; $display("FAIL flush_out_ctrl[%0d]: got %h want 0", k, out_ctrl);
      end
      advance();
    end
    @(negedge reloj);
    n_checks++;
    if (stall_cnt !== 3'd1) begin
      n_fail++; $display("FAIL flush_keeps_stall_cnt: got %0d want 1", stall_cnt);
    end
    advance();
  endtask

  task automatic test_saturate();
    reset_dut();
    in_valid  = 1'b1;
    in_data   = 32'h5A5A5A5A;
    in_ctrl   = 5'h05;
    out_ready = 1'b0;
    @(negedge reloj);
    advance();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      advance();
      @(negedge reloj);
      n_checks++;
      if (stall_cnt !== 3'((k + 1 > STALL_MAX) ? STALL_MAX : k + 1)) begin
        n_fail++;
        $display("FAIL sat_step[%0d]: got %0d want %0d", k, stall_cnt,
                 (k + 1 > STALL_MAX) ? STALL_MAX : k + 1);
      end
    end
    n_checks++;
    if (stall_cnt !== 3'd7) begin
      n_fail++; $display("FAIL sat_final: got %0d want 7", stall_cnt);
    end
    out_ready = 1'b1;
    advance();
  endtask

  task automatic test_async_reset();
    reset_dut();
    in_valid  = 1'b1;
    in_data   = 32'h77778888;
    in_ctrl   = 5'h17;
    out_ready = 1'b0;
    @(negedge reloj);
    advance();
    @(negedge reloj);
    advance();
    @(negedge reloj);
    advance();
    #2;
    resetM = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_ctrl !== 5'h0) begin
      n_fail++;
      $display("FAIL async_reset_outs: got v=%b d=%h c=%h want all 0",
               out_valid, out_data, out_ctrl);
    end
    n_checks++;
    if (stall_cnt !== 3'd0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_ctl: got stall=%0d rdy=%b want 0 0", stall_cnt, in_ready);
    end
    model_clear();
    in_valid = 1'b0;
    @(negedge reloj);
    resetM = 1'b1;
    advance();
    @(negedge reloj);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_no_survivor: got v=%b want 0", out_valid);
    end
    advance();
  endtask

  task automatic random_cycle(input logic v, input logic r, input logic want_ready_1);
    in_valid  = v;
    out_ready = r;
    in_data   = $urandom;
    in_ctrl   = 5'($urandom);
    @(negedge reloj);
    n_checks++;
    if (in_ready !== model_ready()) begin
      n_fail++; $display("FAIL rand_in_ready: got %b want %b", in_ready, model_ready());
    end
    if (want_ready_1) begin
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL throughput_in_ready: got %b want 1", in_ready);
      end
    end
    n_checks++;
    if (out_valid !== model_valid()) begin
      n_fail++; $display("FAIL rand_out_valid: got %b want %b", out_valid, model_valid());
    end
    if (model_valid()) begin
      n_checks++;
      if (out_data !== q_data[0] || out_ctrl !== q_ctrl[0]) begin
        n_fail++;
        $display("FAIL rand_order: got d=%h c=%h want d=%h c=%h",
                 out_data, out_ctrl, q_data[0], q_ctrl[0]);
      end
    end
    n_checks++;
    if (stall_cnt !== 3'(stall_model)) begin
      n_fail++; $display("FAIL rand_stall_cnt: got %0d want %0d", stall_cnt, stall_model);
    end
    advance();
  endtask

  task automatic test_random();
    reset_dut();
    n_in  = 0;
    n_out = 0;
    for (int k = 0; k < 100; k++) begin
      random_cycle(1'($urandom), 1'($urandom), 1'b0);
    end
    // Drain, then run a fully open stream that must accept every cycle.
    for (int k = 0; k < 3; k++) random_cycle(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 30; k++) random_cycle(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) random_cycle(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (n_out !== n_in || n_in < 30) begin
      n_fail++; $display("FAIL rand_word_count: got out=%0d want in=%0d", n_out, n_in);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_saturate();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
